// File: rtl/fmul_fma_front_pipe.sv
// Two-stage FP multiplier front end for the FMA path: exact, unrounded a*b in the
// widened format the fadd pipe consumes, with addend/op/rm and special flags forwarded.
module fmul_fma_front_pipe #(
  parameter int unsigned EXPWIDTH  = 8,
  parameter int unsigned PRECISION = 24,
  parameter int unsigned LEN       = EXPWIDTH + PRECISION
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [2:0]             in_op_i,
  input  logic [LEN-1:0]         in_a_i,
  input  logic [LEN-1:0]         in_b_i,
  input  logic [LEN-1:0]         in_c_i,
  input  logic [2:0]             in_rm_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [2:0]             out_op_o,
  output logic [2:0]             out_rm_o,
  output logic                   out_prod_sign_o,
  output logic [EXPWIDTH-1:0]    out_prod_exp_o,
  output logic [2*PRECISION-2:0] out_prod_sig_o,
  output logic                   out_is_nan_o,
  output logic                   out_is_inf_o,
  output logic                   out_is_inv_o,
  output logic                   out_overflow_o,
  output logic [LEN-1:0]         out_add_another_o
);

  localparam int unsigned FRACW = PRECISION - 1;
  localparam int unsigned PRODW = 2 * PRECISION;
  localparam int unsigned SIGW  = 2 * PRECISION - 1;
  localparam int unsigned SEXPW = EXPWIDTH + 3;
  localparam int unsigned LZCW  = $clog2(PRODW + 1);
  localparam int unsigned BIAS  = (2 ** (EXPWIDTH - 1)) - 1;
  localparam int unsigned EMAX  = (2 ** EXPWIDTH) - 1;

  typedef struct packed {
    logic                 sign;
    logic [EXPWIDTH-1:0]  exp_eff;
    logic [PRECISION-1:0] sig;
    logic                 zero;
    logic                 inf;
    logic                 nan;
    logic                 snan;
  } unpk_t;

  typedef struct packed {
    logic                 sign;
    logic [SEXPW-1:0]     exp_sum;
    logic [PRECISION-1:0] sig_a;
    logic [PRECISION-1:0] sig_b;
    logic                 nan;
    logic                 inf;
    logic                 inv;
    logic                 zero;
    logic [2:0]           op;
    logic [2:0]           rm;
    logic [LEN-1:0]       c;
  } s1_t;

  typedef struct packed {
    logic                 sign;
    logic [EXPWIDTH-1:0]  exp;
    logic [SIGW-1:0]      sig;
    logic                 nan;
    logic                 inf;
    logic                 inv;
    logic                 ovf;
    logic [2:0]           op;
    logic [2:0]           rm;
    logic [LEN-1:0]       c;
  } s2_t;

  // Field split and class decode; subnormals get hidden bit 0 and exponent 1.
  function automatic unpk_t unpack(input logic [LEN-1:0] x);
    unpk_t               u;
    logic [EXPWIDTH-1:0] e;
    logic [FRACW-1:0]    f;
    e         = x[LEN-2 -: EXPWIDTH];
    f         = x[FRACW-1:0];
    u.sign    = x[LEN-1];
    u.exp_eff = (e == '0) ? EXPWIDTH'(1) : e;
    u.sig     = {(e != '0), f};
    u.zero    = (e == '0) && (f == '0);
    u.inf     = (e == '1) && (f == '0);
    u.nan     = (e == '1) && (f != '0);
    u.snan    = u.nan && !f[FRACW-1];
    return u;
  endfunction

  function automatic logic [LZCW-1:0] lzc_f(input logic [PRODW-1:0] x);
    logic [LZCW-1:0] n;
    logic            found;
    n     = '0;
    found = 1'b0;
    for (int i = PRODW - 1; i >= 0; i--) begin
      if (!found) begin
        if (x[i]) found = 1'b1;
        else      n = n + LZCW'(1);
      end
    end
    return n;
  endfunction

  logic  v1_q, v1_d, v2_q, v2_d;
  logic  s1_adv, s2_adv;
  s1_t   s1_q, s1_d, s1_n;
  s2_t   s2_q, s2_d, s2_n;
  unpk_t ua, ub;

  logic [PRODW-1:0]        prod, mant_n;
  logic [LZCW-1:0]         lzc;
  logic signed [SEXPW-1:0] exp_n;
  logic [SEXPW-1:0]        shamt;
  logic [SIGW-1:0]         sub_sig;
  logic                    sticky;

  assign s2_adv     = !v2_q || out_ready_i;
  assign s1_adv     = !v1_q || s2_adv;
  assign in_ready_o = s1_adv;

  // Stage 1: unpack, exponent sum, special-case classification.
  always_comb begin
    ua           = unpack(in_a_i);
    ub           = unpack(in_b_i);
    s1_n.sign    = ua.sign ^ ub.sign ^ in_op_i[1];
    s1_n.exp_sum = SEXPW'(ua.exp_eff) + SEXPW'(ub.exp_eff) - SEXPW'(BIAS) + SEXPW'(1);
    s1_n.sig_a   = ua.sig;
    s1_n.sig_b   = ub.sig;
    s1_n.inv     = (ua.inf && ub.zero) || (ua.zero && ub.inf) || ua.snan || ub.snan;
    s1_n.nan     = ua.nan || ub.nan || s1_n.inv;
    s1_n.inf     = (ua.inf || ub.inf) && !s1_n.nan;
    s1_n.zero    = ua.zero || ub.zero;
    s1_n.op      = in_op_i;
    s1_n.rm      = in_rm_i;
    s1_n.c       = in_c_i;
  end

  // Stage 2: full product, normalize, subnormal denormalize with sticky.
  always_comb begin
    prod   = PRODW'(s1_q.sig_a) * PRODW'(s1_q.sig_b);
    lzc    = lzc_f(prod);
    mant_n = prod << lzc;
    exp_n  = $signed(s1_q.exp_sum) - $signed(SEXPW'(lzc));
    shamt  = SEXPW'(1) - $unsigned(exp_n);
    if (shamt >= SEXPW'(PRODW)) begin
      sub_sig = '0;
      sticky  = |mant_n;
    end else begin
      sub_sig = SIGW'(mant_n >> shamt);
      sticky  = |(mant_n & ~({PRODW{1'b1}} << shamt));
    end

    s2_n      = '0;
    s2_n.sign = s1_q.sign;
    s2_n.nan  = s1_q.nan;
    s2_n.inf  = s1_q.inf;
    s2_n.inv  = s1_q.inv;
    s2_n.op   = s1_q.op;
    s2_n.rm   = s1_q.rm;
    s2_n.c    = s1_q.c;
    if (s1_q.nan) begin
      s2_n.sign = 1'b0;
      s2_n.exp  = '1;
      s2_n.sig  = {1'b1, {(SIGW - 1){1'b0}}};
    end else if (s1_q.inf) begin
      s2_n.exp = '1;
    end else if (s1_q.zero) begin
      s2_n.exp = '0;
    end else if (exp_n >= $signed(SEXPW'(EMAX))) begin
      s2_n.ovf = 1'b1;
      s2_n.exp = '1;
    end else if (exp_n[SEXPW-1] || (exp_n == '0)) begin
      s2_n.sig = sub_sig | SIGW'(sticky);
    end else begin
      s2_n.exp = EXPWIDTH'($unsigned(exp_n));
      s2_n.sig = mant_n[SIGW-1:0];
    end
  end

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    s1_d = s1_q;
    s2_d = s2_q;
    if (s1_adv) v1_d = in_valid_i;
    if (s2_adv) v2_d = v1_q;
    if (s1_adv && in_valid_i) s1_d = s1_n;
    if (s2_adv && v1_q)       s2_d = s2_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign out_valid_o       = v2_q;
  assign out_op_o          = s2_q.op;
  assign out_rm_o          = s2_q.rm;
  assign out_prod_sign_o   = s2_q.sign;
  assign out_prod_exp_o    = s2_q.exp;
  assign out_prod_sig_o    = s2_q.sig;
  assign out_is_nan_o      = s2_q.nan;
  assign out_is_inf_o      = s2_q.inf;
  assign out_is_inv_o      = s2_q.inv;
  assign out_overflow_o    = s2_q.ovf;
  assign out_add_another_o = s2_q.c;

endmodule

// File: tb/tb_fmul_fma_front_pipe.sv
// Self-checking bench for fmul_fma_front_pipe: directed corner cases, randomized
// traffic with random backpressure against an arithmetic reference model, stall and reset.
module tb_fmul_fma_front_pipe;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [46:0] sig;
    logic        nan;
    logic        inf;
    logic        inv;
    logic        ovf;
    logic [2:0]  op;
    logic [2:0]  rm;
    logic [31:0] c;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_op, in_rm;
  logic [31:0] in_a, in_b, in_c;
  logic [2:0]  o_op, o_rm;
  logic        o_sign, o_nan, o_inf, o_inv, o_ovf;
  logic [7:0]  o_exp;
  logic [46:0] o_sig;
  logic [31:0] o_c;
  res_t        got;
  res_t        exp_q[$];
  int          n_vec, n_err;

  always #5 clk = ~clk;

  fmul_fma_front_pipe dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_op_i          (in_op),
    .in_a_i           (in_a),
    .in_b_i           (in_b),
    .in_c_i           (in_c),
    .in_rm_i          (in_rm),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_op_o         (o_op),
    .out_rm_o         (o_rm),
    .out_prod_sign_o  (o_sign),
    .out_prod_exp_o   (o_exp),
    .out_prod_sig_o   (o_sig),
    .out_is_nan_o     (o_nan),
    .out_is_inf_o     (o_inf),
    .out_is_inv_o     (o_inv),
    .out_overflow_o   (o_ovf),
    .out_add_another_o(o_c)
  );

  assign got = {o_sign, o_exp, o_sig, o_nan, o_inf, o_inv, o_ovf, o_op, o_rm, o_c};

  // Reference: product value p * 2^(ea+eb-127-46) expressed in the widened format.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [2:0] op,
                                 input logic [2:0] rm);
    res_t            r;
    int              ea, eb, e, top, k;
    longint unsigned fa, fb, ma, mb, p, m;
    bit              na, nb, sna, snb, ia, ib, za, zb, inv, sticky;
    r = '0; r.op = op; r.rm = rm; r.c = c;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = 64'(a[22:0]);   fb = 64'(b[22:0]);
    na = (ea == 255) && (fa != 0);  nb = (eb == 255) && (fb != 0);
    sna = na && !a[22];             snb = nb && !b[22];
    ia = (ea == 255) && (fa == 0);  ib = (eb == 255) && (fb == 0);
    za = (ea == 0) && (fa == 0);    zb = (eb == 0) && (fb == 0);
    inv = (ia && zb) || (za && ib) || sna || snb;
    r.sign = a[31] ^ b[31] ^ op[1];
    if (na || nb || inv) begin
      r.nan = 1'b1; r.inv = inv; r.sign = 1'b0; r.exp = 8'hFF; r.sig = 47'h4000_0000_0000;
    end else if (ia || ib) begin
      r.inf = 1'b1; r.exp = 8'hFF;
    end else if (!(za || zb)) begin
      ma = (ea == 0) ? fa : fa + 64'h80_0000;
      mb = (eb == 0) ? fb : fb + 64'h80_0000;
      if (ea == 0) ea = 1;
      if (eb == 0) eb = 1;
      p = ma * mb;
      top = 47;
      while (top > 0 && ((p >> top) & 64'd1) == 64'd0) top--;
      e = ea + eb - 127 + top - 46;
      if (e >= 255) begin
        r.ovf = 1'b1; r.exp = 8'hFF;
      end else if (e >= 1) begin
        r.exp = 8'(e);
        m = p << (47 - top);
        r.sig = 47'(m);
      end else begin
        k = ea + eb - 127;
        sticky = 1'b0;
        if (k >= 0) m = p << k;
        else if (k <= -64) begin m = 0; sticky = (p != 0); end
        else begin m = p >> (-k); sticky = (p & ((64'd1 << (-k)) - 64'd1)) != 0; end
        r.sig = 47'(m) | 47'(sticky);
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] f;
    int          sel;
    sel = int'($urandom_range(0, 9));
    f   = 23'($urandom);
    case (sel)
      0:       e = 8'd0;
      1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
      2:       begin e = 8'd0; f = '0; end
      3, 4:    e = 8'($urandom_range(1, 30));
      5, 6:    e = 8'($urandom_range(190, 254));
      default: e = 8'($urandom);
    endcase
    return {1'($urandom), e, f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_vec++;
    if (out_valid !== 1'b0 || got !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b data=%h required valid=0 data=0", out_valid, got);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  localparam int ND = 13;
  localparam logic [31:0] D_A [ND] = '{32'h3FC00000, 32'h3FC00000, 32'h7F800000, 32'h7F800000,
    32'h7F000000, 32'h00800000, 32'h7F800001, 32'h7FC00000, 32'h80000000, 32'h00000001,
    32'h3F800000, 32'h40000000, 32'hFF800000};
  localparam logic [31:0] D_B [ND] = '{32'h40000000, 32'h40000000, 32'h00000000, 32'h3F800000,
    32'h7F000000, 32'h00800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h4B000000,
    32'h7F000000, 32'h7F000000, 32'h3F800000};
  localparam logic [2:0] D_OP [ND] = '{3'b100, 3'b110, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000,
    3'b010, 3'b100, 3'b100, 3'b011, 3'b100, 3'b000};
  localparam logic D_SIGN [ND] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
    1'b1, 1'b0, 1'b1};
  localparam logic [7:0] D_EXP [ND] = '{8'h80, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF,
    8'h00, 8'h01, 8'hFE, 8'hFF, 8'hFF};
  localparam logic [46:0] D_SIG [ND] = '{47'h4000_0000_0000, 47'h4000_0000_0000,
    47'h4000_0000_0000, 47'h0, 47'h0, 47'h1, 47'h4000_0000_0000, 47'h4000_0000_0000, 47'h0,
    47'h0, 47'h0, 47'h0, 47'h0};
  // {nan, inf, inv, ovf}
  localparam logic [3:0] D_FLG [ND] = '{4'b0000, 4'b0000, 4'b1010, 4'b0100, 4'b0001, 4'b0000,
    4'b1010, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0100};

  task automatic test_directed();
    res_t e;
    out_ready = 1'b1;
    for (int i = 0; i < ND; i++) begin
      in_valid = 1'b1; in_a = D_A[i]; in_b = D_B[i]; in_op = D_OP[i];
      in_c = $urandom; in_rm = 3'($urandom);
      e = {D_SIGN[i], D_EXP[i], D_SIG[i], D_FLG[i], D_OP[i], in_rm, in_c};
      tick();
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL directed_early[%0d]: out_valid=%b one cycle after accept, required 0", i, out_valid);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: out_valid=%b two cycles after accept, required 1", i, out_valid);
      end
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL directed_data[%0d]: got %h required %h", i, got, e);
      end
    end
    tick();
  endtask

  task automatic test_random(input int ncyc, input int pv, input int pr);
    res_t e;
    bit   feeding;
    exp_q.delete();
    for (int cyc = 0; cyc < ncyc + 40; cyc++) begin
      feeding   = (cyc < ncyc);
      in_valid  = feeding && ($urandom_range(0, 99) < pv);
      in_a      = rnd_op();
      in_b      = rnd_op();
      in_c      = $urandom;
      in_op     = 3'($urandom);
      in_rm     = 3'($urandom);
      out_ready = !feeding || ($urandom_range(0, 99) < pr);
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL random_extra: unexpected output %h, none outstanding", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL random_data: got %h required %h", got, e);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_c, in_op, in_rm));
      tick();
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL random_drain: %0d outputs missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta [4], tb [4], tc [4];
    logic [2:0]  to [4], tr [4];
    res_t        em [4];
    int          idx, oidx;
    for (int i = 0; i < 4; i++) begin
      ta[i] = rnd_op(); tb[i] = rnd_op(); tc[i] = $urandom;
      to[i] = 3'($urandom); tr[i] = 3'($urandom);
      em[i] = model(ta[i], tb[i], tc[i], to[i], tr[i]);
    end
    idx = 0; oidx = 0; out_ready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid = 1'b1; in_a = ta[idx]; in_b = tb[idx]; in_c = tc[idx];
      in_op = to[idx]; in_rm = tr[idx];
      @(negedge clk);
      if (cyc >= 3) begin
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || got !== em[0]) begin
          n_err++;
          $display("FAIL b2b_hold: ready=%b valid=%b data=%h required ready=0 valid=1 data=%h",
                   in_ready, out_valid, got, em[0]);
        end
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    n_vec++;
    if (idx != 2) begin
      n_err++;
      $display("FAIL b2b_fill: %0d accepted while stalled, required 2", idx);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        in_a = ta[idx]; in_b = tb[idx]; in_c = tc[idx]; in_op = to[idx]; in_rm = tr[idx];
      end
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || got !== em[oidx]) begin
        n_err++;
        $display("FAIL b2b_drain[%0d]: valid=%b data=%h required valid=1 data=%h",
                 oidx, out_valid, got, em[oidx]);
      end
      oidx++;
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || idx != 4) begin
      n_err++;
      $display("FAIL b2b_end: valid=%b accepted=%0d required valid=0 accepted=4", out_valid, idx);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    res_t e;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = rnd_op(); in_b = rnd_op(); in_c = $urandom;
      in_op = 3'($urandom); in_rm = 3'($urandom);
      tick();
    end
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_full: valid=%b ready=%b required valid=1 ready=0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || got !== '0) begin
      n_err++;
      $display("FAIL rstmid_flush: valid=%b data=%h required valid=0 data=0", out_valid, got);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    in_valid = 1'b1; in_a = 32'h40400000; in_b = 32'hC0A00000; in_c = $urandom;
    in_op = 3'b101; in_rm = 3'b011; out_ready = 1'b1;
    e = model(in_a, in_b, in_c, in_op, in_rm);
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_early: out_valid=%b one cycle after accept, required 0", out_valid);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || got !== e) begin
      n_err++;
      $display("FAIL rstmid_first: valid=%b data=%h required valid=1 data=%h", out_valid, got, e);
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_op = '0; in_rm = '0;
    #12;
    test_reset();
    test_directed();
    test_random(400, 70, 70);
    test_random(200, 100, 40);
    test_back_to_back();
    test_reset_midstream();
    test_random(100, 90, 100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
